// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and width defaults.
package lsu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // funct3[1:0] encodes access size: 00 byte, 01 halfword, 10 word.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data_o = rdata_i;
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit with req/ack memory handshake, one op in flight.
// Build option: define LSU_MISALIGN_TRAP_EN to turn misaligned accesses into errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_valid,
  input  logic              in_we,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_store_data,
  output logic              out_ready,
  output logic              out_done,
  output logic [DATA_W-1:0] out_load_data,
  output logic              out_error,
  output logic              out_mem_req,
  output logic              out_mem_we,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_wdata,
  output logic [3:0]        out_mem_wstrb,
  input  logic              in_mem_ack,
  input  logic [DATA_W-1:0] in_mem_rdata,
  output logic [1:0]        out_dbg_state
);

  // Handshake: an op is accepted on an edge where in_valid=1 and out_ready=1;
  // memory completes on an edge where out_mem_req=1 and in_mem_ack=1.
  state_e            state_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sdata_q;
  logic              mem_req_q;
  logic              err_q;
  logic [DATA_W-1:0] ldata_q;
  logic [DATA_W-1:0] ext_data;
  logic              reject;

`ifdef LSU_MISALIGN_TRAP_EN
  assign reject = !f3_legal(in_we, in_funct3) || f3_misaligned(in_funct3, in_addr[1:0]);
`else
  assign reject = !f3_legal(in_we, in_funct3);
`endif

  lsu_load_extract u_extract (
    .rdata_i   (in_mem_rdata),
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .data_o    (ext_data)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'd0;
      addr_q    <= '0;
      sdata_q   <= '0;
      mem_req_q <= 1'b0;
      err_q     <= 1'b0;
      ldata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            we_q     <= in_we;
            funct3_q <= in_funct3;
            addr_q   <= in_addr;
            sdata_q  <= in_store_data;
            if (reject) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              mem_req_q <= 1'b1;
              state_q   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (in_mem_ack) begin
            mem_req_q <= 1'b0;
            if (!we_q) ldata_q <= ext_data;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Result fields only carry meaning during the done pulse.
          err_q   <= 1'b0;
          ldata_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_mem_wdata = sdata_q;
    out_mem_wstrb = 4'b0000;
    if (we_q) begin
      case (funct3_q)
        F3_SB: begin
          out_mem_wdata = {4{sdata_q[7:0]}};
          out_mem_wstrb = 4'b0001 << addr_q[1:0];
        end
        F3_SH: begin
          out_mem_wdata = {2{sdata_q[15:0]}};
          out_mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        end
        F3_SW:   out_mem_wstrb = 4'b1111;
        default: out_mem_wstrb = 4'b0000;
      endcase
    end
  end

  assign out_ready     = (state_q == ST_IDLE);
  assign out_done      = (state_q == ST_DONE);
  assign out_error     = err_q;
  assign out_load_data = ldata_q;
  assign out_mem_req   = mem_req_q;
  assign out_mem_we    = we_q;
  assign out_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign out_dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_we, in_mem_ack;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_store_data, in_mem_rdata;
  logic        out_ready, out_done, out_error, out_mem_req, out_mem_we;
  logic [31:0] out_load_data, out_mem_addr, out_mem_wdata;
  logic [3:0]  out_mem_wstrb;
  logic [1:0]  out_dbg_state;

  typedef struct {
    logic        err;
    logic        we;
    logic [31:0] ldata;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   run_chk = 1'b0;

  load_store_unit dut (
    .in_clk        (clk),
    .in_rst        (rst),
    .in_valid      (in_valid),
    .in_we         (in_we),
    .in_funct3     (in_funct3),
    .in_addr       (in_addr),
    .in_store_data (in_store_data),
    .out_ready     (out_ready),
    .out_done      (out_done),
    .out_load_data (out_load_data),
    .out_error     (out_error),
    .out_mem_req   (out_mem_req),
    .out_mem_we    (out_mem_we),
    .out_mem_addr  (out_mem_addr),
    .out_mem_wdata (out_mem_wdata),
    .out_mem_wstrb (out_mem_wstrb),
    .in_mem_ack    (in_mem_ack),
    .in_mem_rdata  (in_mem_rdata),
    .out_dbg_state (out_dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: outcome of one op from the ISA rules, using plain arithmetic.
  function automatic exp_t ref_op(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] sd,
                                  input logic [31:0] rd);
    exp_t e;
    int off, sz, sh;
    logic legal;
    logic [31:0] v;
    e = '{err: 1'b0, we: we, ldata: 32'd0, maddr: 32'd0, wdata: 32'd0, wstrb: 4'd0, done_cyc: 0};
    off = int'(addr[1:0]);
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz = 1 << f3[1:0];
    e.err = !legal || (TRAP && (off % sz) != 0);
    e.maddr = addr - 32'(off);
    if (!e.err) begin
      if (we) begin
        if (sz == 1) begin
          e.wdata = 32'(sd[7:0]) * 32'h01010101;
          e.wstrb = 4'(1 << off);
        end else if (sz == 2) begin
          e.wdata = 32'(sd[15:0]) * 32'h00010001;
          e.wstrb = 4'(3 << ((off / 2) * 2));
        end else begin
          e.wdata = sd;
          e.wstrb = 4'hF;
        end
      end else if (sz == 4) begin
        e.ldata = rd;
      end else begin
        sh = (sz == 1) ? 8 * off : 16 * (off / 2);
        v = (rd >> sh) & ((sz == 1) ? 32'hFF : 32'hFFFF);
        if (!f3[2] && v >= ((sz == 1) ? 32'd128 : 32'd32768))
          v = v - ((sz == 1) ? 32'd256 : 32'd65536);
        e.ldata = v;
      end
    end
    return e;
  endfunction

  // scoreboard: one compare per output per cycle against the head of exp_q
  always @(negedge clk) begin
    if (run_chk) begin
      if (exp_q.size() == 0) begin
        chk("ready_idle", 32'(out_ready), 32'd1);
        chk("done_idle", 32'(out_done), 32'd0);
        chk("req_idle", 32'(out_mem_req), 32'd0);
      end else begin
        cur = exp_q[0];
        chk("ready_busy", 32'(out_ready), 32'd0);
        chk("done", 32'(out_done), 32'(cyc == cur.done_cyc));
        chk("req", 32'(out_mem_req), 32'(!cur.err && cyc < cur.done_cyc));
        if (!cur.err && cyc < cur.done_cyc) begin
          chk("mem_addr", out_mem_addr, cur.maddr);
          chk("mem_we", 32'(out_mem_we), 32'(cur.we));
          chk("mem_wstrb", 32'(out_mem_wstrb), 32'(cur.wstrb));
          if (cur.we) chk("mem_wdata", out_mem_wdata, cur.wdata);
        end
        if (cyc >= cur.done_cyc) begin
          chk("error", 32'(out_error), 32'(cur.err));
          chk("load_data", out_load_data, cur.ldata);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!out_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_ready) chk("ready_timeout", 32'(out_ready), 32'd1);
  endtask

  // driver: issue one op, play the memory with w wait cycles, optionally poke in_valid while busy
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [31:0] rd, input int w,
                       input bit noise);
    exp_t e;
    int n;
    wait_ready();
    in_valid = 1'b1; in_we = we; in_funct3 = f3; in_addr = addr; in_store_data = sd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e = ref_op(we, f3, addr, sd, rd);
    e.done_cyc = e.err ? cyc : cyc + 1 + w;
    exp_q.push_back(e);
    if (!e.err) begin
      @(negedge clk);
      repeat (w) begin
        if (noise) begin
          in_valid = 1'b1; in_we = 1'($urandom); in_funct3 = 3'($urandom);
          in_addr = $urandom; in_store_data = $urandom;
        end
        in_mem_rdata = $urandom;
        @(negedge clk);
      end
      in_valid = 1'b0;
      in_mem_ack = 1'b1;
      in_mem_rdata = rd;
      @(negedge clk);
      in_mem_ack = 1'b0;
      in_mem_rdata = $urandom;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  exp_t pin;
  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_we = 1'b0; in_funct3 = 3'd0; in_addr = 32'd0;
    in_store_data = 32'd0; in_mem_ack = 1'b0; in_mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(out_ready), 32'd1);
    chk("rst_done", 32'(out_done), 32'd0);
    chk("rst_error", 32'(out_error), 32'd0);
    chk("rst_ldata", out_load_data, 32'd0);
    chk("rst_req", 32'(out_mem_req), 32'd0);
    chk("rst_we", 32'(out_mem_we), 32'd0);
    chk("rst_addr", out_mem_addr, 32'd0);
    chk("rst_wdata", out_mem_wdata, 32'd0);
    chk("rst_wstrb", 32'(out_mem_wstrb), 32'd0);
    rst = 1'b0;

    // hand-computed values that pin the model itself
    pin = ref_op(1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF1234);
    chk("pin_lb", pin.ldata, 32'hFFFFFF80);
    pin = ref_op(1'b0, 3'd4, 32'h103, 32'd0, 32'h80FF1234);
    chk("pin_lbu", pin.ldata, 32'h00000080);
    pin = ref_op(1'b0, 3'd5, 32'h102, 32'd0, 32'h80FF1234);
    chk("pin_lhu", pin.ldata, 32'h000080FF);
    pin = ref_op(1'b1, 3'd0, 32'h201, 32'h000000AB, 32'd0);
    chk("pin_sb_wdata", pin.wdata, 32'hABABABAB);
    chk("pin_sb_wstrb", 32'(pin.wstrb), 32'h2);
    pin = ref_op(1'b1, 3'd1, 32'h202, 32'h00001234, 32'd0);
    chk("pin_sh_wdata", pin.wdata, 32'h12341234);
    chk("pin_sh_wstrb", 32'(pin.wstrb), 32'hC);
    pin = ref_op(1'b0, 3'd3, 32'h100, 32'd0, 32'd0);
    chk("pin_illegal", 32'(pin.err), 32'd1);

    run_chk = 1'b1;
    @(negedge clk);
    do_op(1'b0, 3'd2, 32'h100, 32'h5555AAAA, 32'hDEADBEEF, 0, 1'b0);
    do_op(1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF1234, 0, 1'b0);
    do_op(1'b0, 3'd4, 32'h103, 32'd0, 32'h80FF1234, 0, 1'b0);
    do_op(1'b0, 3'd5, 32'h102, 32'd0, 32'h80FF1234, 0, 1'b0);
    do_op(1'b1, 3'd0, 32'h201, 32'h000000AB, 32'd0, 0, 1'b0);
    do_op(1'b1, 3'd1, 32'h202, 32'h00001234, 32'd0, 0, 1'b0);
    do_op(1'b0, 3'd2, 32'h101, 32'd0, 32'hCAFEF00D, 0, 1'b0);
    do_op(1'b0, 3'd1, 32'h103, 32'd0, 32'h9876ABCD, 1, 1'b0);
    do_op(1'b0, 3'd3, 32'h100, 32'd0, 32'd0, 0, 1'b0);
    do_op(1'b1, 3'd3, 32'h100, 32'd0, 32'd0, 0, 1'b0);
    do_op(1'b0, 3'd2, 32'h300, 32'd0, 32'h01234567, 3, 1'b1);

    // stray ack while idle must be ignored
    wait_ready();
    in_mem_ack = 1'b1; in_mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    in_mem_ack = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of REQ, then a late ack
    wait_ready();
    in_valid = 1'b1; in_we = 1'b0; in_funct3 = 3'd2; in_addr = 32'h400;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pin = ref_op(1'b0, 3'd2, 32'h400, 32'd0, 32'd0);
    pin.done_cyc = cyc + 100;
    exp_q.push_back(pin);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    in_mem_ack = 1'b1; in_mem_rdata = 32'h13572468;
    @(negedge clk);
    in_mem_ack = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 120; i++) begin
      logic we;
      logic [2:0] f3;
      we = 1'($urandom);
      if ($urandom_range(0, 9) < 8)
        f3 = we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom);
      do_op(we, f3, $urandom & 32'h0000FFFF, $urandom, $urandom,
            int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        in_mem_ack = 1'b1;
        @(negedge clk);
        in_mem_ack = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
